// File: rtl/batalha_pkg.sv
// Shared types for the shot tracker: FSM states, shot-result codes,
// board geometry defaults and the valid-cell mask helper.
package batalha_pkg;

   localparam int GRID_CELLS_DEF = 36;
   localparam int MAP_W          = 36;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      OVER
   } state_t;

   typedef enum logic [1:0] {
      RES_HIT,
      RES_MISS,
      RES_REPEAT,
      RES_INVALID
   } res_t;

   function automatic logic [MAP_W-1:0] cell_mask(input int n);
      logic [MAP_W-1:0] m;
      m = '0;
      for (int i = 0; i < MAP_W; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/fire_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge pulse for the fire button.
// The detector stays disarmed after reset until the button is seen released.
module fire_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_pulse
);

   logic       r_meta;
   logic       r_sync;
   logic       r_prev;
   logic       r_armed;
   logic       r_pulse;
   logic [1:0] r_fill;
   logic       w_fill_done;

   assign w_fill_done = (r_fill == 2'd2);
   assign o_pulse     = r_pulse;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_prev  <= 1'b0;
         r_armed <= 1'b0;
         r_pulse <= 1'b0;
         r_fill  <= 2'd0;
      end else begin
         r_meta  <= i_async;
         r_sync  <= r_meta;
         r_prev  <= r_sync;
         if (!w_fill_done) r_fill <= r_fill + 2'd1;
         // r_sync only reflects the pin once the pipeline has refilled
         if (w_fill_done && !r_sync) r_armed <= 1'b1;
         r_pulse <= r_sync & ~r_prev & r_armed;
      end
   end

endmodule

// File: rtl/shot_tracker.sv
// Battleship shot tracker: classifies shots, keeps board and score state.
// Optional shot budget enabled with the SHOT_LIMIT_EN macro.
module shot_tracker
   import batalha_pkg::*;
#(
   parameter int GRID_CELLS = GRID_CELLS_DEF,
   parameter int MAX_SHOTS  = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  X,
   input  logic        fire,
   input  logic        new_game,
   input  logic [35:0] ship_map,
   output logic        result_valid,
   output logic        hit,
   output logic        miss,
   output logic        repeat_shot,
   output logic        invalid,
   output logic [35:0] shot_map,
   output logic [5:0]  hits_cnt,
   output logic [5:0]  shots_fired,
   output logic        game_over,
   output logic        win
);

   localparam logic [MAP_W-1:0] CELLS = cell_mask(GRID_CELLS);
   localparam logic [5:0]       CAP   = 6'(GRID_CELLS);

   state_t             r_state;
   state_t             w_state_nx;
   logic [MAP_W-1:0]   r_ship;
   logic [MAP_W-1:0]   r_shot;
   logic [5:0]         r_hits;
   logic [5:0]         r_shots;
   logic               r_over;
   logic               r_win;
   logic               r_valid;
   res_t               r_res;

   logic [MAP_W-1:0]   w_ship_nx;
   logic [MAP_W-1:0]   w_shot_nx;
   logic [5:0]         w_hits_nx;
   logic [5:0]         w_shots_nx;
   logic               w_over_nx;
   logic               w_win_nx;
   logic               w_valid_nx;
   res_t               w_res_nx;

   logic               w_fire;
   logic [MAP_W-1:0]   w_onehot;
   logic               w_oob;
   logic               w_fired;
   logic               w_is_ship;

   fire_edge_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (fire),
      .o_pulse (w_fire)
   );

   assign w_onehot  = 36'd1 << X;
   assign w_oob     = (X >= CAP);
   assign w_fired   = |(r_shot & w_onehot);
   assign w_is_ship = |(r_ship & w_onehot);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_ship_nx  = r_ship;
      w_shot_nx  = r_shot;
      w_hits_nx  = r_hits;
      w_shots_nx = r_shots;
      w_over_nx  = r_over;
      w_win_nx   = r_win;
      w_valid_nx = 1'b0;
      w_res_nx   = r_res;
      if (new_game) begin
         // a coincident fire pulse is dropped here
         w_ship_nx  = ship_map & CELLS;
         w_shot_nx  = '0;
         w_hits_nx  = '0;
         w_shots_nx = '0;
         w_over_nx  = 1'b0;
         w_win_nx   = 1'b0;
         w_state_nx = PLAY;
         if (w_ship_nx == '0) begin
            w_over_nx  = 1'b1;
            w_win_nx   = 1'b1;
            w_state_nx = OVER;
         end
      end else if (r_state == PLAY && w_fire) begin
         w_valid_nx = 1'b1;
         unique case (1'b1)
            w_oob:   w_res_nx = RES_INVALID;
            w_fired: w_res_nx = RES_REPEAT;
            default: begin
               w_shot_nx = r_shot | w_onehot;
               if (r_shots != CAP) w_shots_nx = r_shots + 6'd1;
               if (w_is_ship) begin
                  w_res_nx = RES_HIT;
                  if (r_hits != CAP) w_hits_nx = r_hits + 6'd1;
               end else begin
                  w_res_nx = RES_MISS;
               end
               if ((r_ship & ~w_shot_nx) == '0) begin
                  w_over_nx  = 1'b1;
                  w_win_nx   = 1'b1;
                  w_state_nx = OVER;
               end
`ifdef SHOT_LIMIT_EN
               else if (w_shots_nx == 6'(MAX_SHOTS)) begin
                  w_over_nx  = 1'b1;
                  w_state_nx = OVER;
               end
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ship  <= '0;
         r_shot  <= '0;
         r_hits  <= '0;
         r_shots <= '0;
         r_over  <= 1'b0;
         r_win   <= 1'b0;
         r_valid <= 1'b0;
         r_res   <= RES_HIT;
      end else begin
         r_ship  <= w_ship_nx;
         r_shot  <= w_shot_nx;
         r_hits  <= w_hits_nx;
         r_shots <= w_shots_nx;
         r_over  <= w_over_nx;
         r_win   <= w_win_nx;
         r_valid <= w_valid_nx;
         r_res   <= w_res_nx;
      end
   end

   assign result_valid = r_valid;
   assign hit          = r_valid && (r_res == RES_HIT);
   assign miss         = r_valid && (r_res == RES_MISS);
   assign repeat_shot  = r_valid && (r_res == RES_REPEAT);
   assign invalid      = r_valid && (r_res == RES_INVALID);
   assign shot_map     = r_shot;
   assign hits_cnt     = r_hits;
   assign shots_fired  = r_shots;
   assign game_over    = r_over;
   assign win          = r_win;

endmodule

// File: doc/shot_tracker.md
SHOT_TRACKER -- requirements
Module: shot_tracker

Interface
REQ-001 Parameter GRID_CELLS, default 36, number of valid board cells (indices 0..GRID_CELLS-1).
REQ-002 Parameter MAX_SHOTS, default 20, shot budget, used only under SHOT_LIMIT_EN.
REQ-003 Port clk  input  1  single clock, all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port X  input  6  cell index from the coordinate decoder stage.
REQ-006 Port fire  input  1  raw fire button, asynchronous to clk, level.
REQ-007 Port new_game  input  1  synchronous, one-cycle load request.
REQ-008 Port ship_map  input  36  ship occupancy, bit i = ship in cell i; sampled only on new_game.
REQ-009 Port result_valid  output  1  one-cycle strobe qualifying hit/miss/repeat/invalid.
REQ-010 Port hit, miss, repeat, invalid  output  1 each  shot classification, exactly one high when result_valid=1, all low otherwise.
REQ-011 Port shot_map  output  36  cells already fired, for display.
REQ-012 Port hits_cnt  output  6  count of distinct ship cells hit.
REQ-013 Port shots_fired  output  6  count of accepted (hit or miss) shots.
REQ-014 Port game_over, win  output  1 each  end-of-game status, held until new_game or reset.

Function
REQ-015 fire SHALL pass a 2-flop synchronizer then a rising-edge detector; one press yields one internal fire pulse, held level yields no further pulses.
REQ-016 FSM states SHALL be IDLE, PLAY, OVER; reset enters IDLE.
REQ-017 IDLE: fire pulses ignored; new_game -> PLAY.
REQ-018 new_game in any state SHALL load ship_map, clear shot_map, hits_cnt, shots_fired, game_over, win, and enter PLAY next cycle; if ship_map==0, enter OVER with win=1 instead.
REQ-019 new_game and fire pulse in the same cycle: new_game wins, the shot is dropped (no result_valid).
REQ-020 In PLAY, a fire pulse SHALL sample X that cycle; result outputs registered, result_valid high the following cycle for exactly one cycle.
REQ-021 Latency: result_valid SHALL rise on the 3rd rising clk edge after the first edge that samples fire=1.
REQ-022 X>=GRID_CELLS -> invalid; no state change.
REQ-023 shot_map[X]==1 -> repeat; no state change.
REQ-024 Otherwise set shot_map[X], increment shots_fired; ship bit set -> hit and increment hits_cnt, else miss.
REQ-025 After an accepted shot, if every ship cell is in shot_map, enter OVER with win=1, game_over=1.
REQ-026 OVER: fire pulses ignored, no result_valid; counters and shot_map frozen.
REQ-027 Counters SHALL not wrap; maximum reachable value is GRID_CELLS.

Reset
REQ-028 rst_n low SHALL immediately clear all outputs, shot_map, stored ship map, synchronizer flops and counters, and force IDLE, including mid-shot.
REQ-029 After rst_n deasserts, a fire level already high SHALL NOT generate a pulse until released and pressed again.

Configuration
REQ-030 Macro SHOT_LIMIT_EN: when defined, an accepted shot bringing shots_fired to MAX_SHOTS without a win SHALL enter OVER with game_over=1, win=0; a simultaneous win takes priority (win=1).
REQ-031 Without SHOT_LIMIT_EN, shots are unlimited; the game ends only by win; MAX_SHOTS unused.

Structure
REQ-032 Package batalha_pkg SHALL hold the state enum (IDLE, PLAY, OVER), GRID_CELLS default and the shot-result encoding.
REQ-033 Sub-module fire_edge_sync (2-flop synchronizer + rising-edge pulse) SHALL be instantiated once; the FSM and board registers stay in shot_tracker.

Verification
REQ-034 Reset, new_game with ship_map=36'h3, fire at X=0 -> result_valid+hit on 3rd edge, hits_cnt=1, shots_fired=1, shot_map=36'h1.
REQ-035 Fire X=0 again -> repeat, counters unchanged; fire X=40 -> invalid, counters unchanged.
REQ-036 Fire X=1 after REQ-034 -> hit, hits_cnt=2, game_over=1, win=1; further fire X=5 -> no result_valid.
REQ-037 SHOT_LIMIT_EN, MAX_SHOTS=20, ship_map=36'h1, 20 misses on X=1..20 -> 20th gives miss, game_over=1, win=0, shots_fired=20.
REQ-038 new_game asserted same cycle as a fire pulse -> no result_valid, shot_map=0, state PLAY; fire held high 10 cycles -> exactly one result.
REQ-039 rst_n pulled low the cycle after a fire pulse -> no result_valid, all outputs 0, state IDLE.
